// File: rtl/branch_conf_pkg.sv
// ============================================================================
//  Module      : branch_conf_pkg
//  Description : Shared definitions for the branch-network switch
//                configuration reader. Holds the bus message types, the
//                broadcast id, the bus field map and the assembler FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package branch_conf_pkg;

  // Configuration message types carried in bus bits [7:0]
  localparam logic [7:0] TYPE_SET_PC_MAX   = 8'd11;
  localparam logic [7:0] TYPE_SET_PC_LOOP  = 8'd12;
  localparam logic [7:0] TYPE_SWITCH       = 8'd13;
  localparam logic [7:0] TYPE_SWITCH_EXT   = 8'd14;

  // Switch number that addresses every switch when broadcast is enabled
  localparam logic [15:0] BCAST_ID = 16'hFFFF;

  // Bus field map (LSB position and width of each field)
  localparam int TYPE_LSB    = 0;
  localparam int TYPE_W      = 8;
  localparam int NUM_LSB     = 8;
  localparam int NUM_W       = 16;
  localparam int THREAD_LSB  = 24;
  localparam int THREAD_FW   = 4;
  localparam int ADDR_LSB    = 28;
  localparam int ADDR_FW     = 12;
  localparam int PAYLOAD_LSB = 40;
  localparam int PAYLOAD_W   = 24;
  localparam int PC_LSB      = 32;
  localparam int PC_FW       = 32;

  // Assembler FSM states
  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_ASSEMBLE = 1'b1
  } asm_state_e;

  // Number of bus beats needed to carry one switch word
  function automatic int beats_for(input int conf_w);
    return (conf_w + PAYLOAD_W - 1) / PAYLOAD_W;
  endfunction

endpackage

`default_nettype wire

// File: rtl/branch_conf_assembler.sv
// ============================================================================
//  Module      : branch_conf_assembler
//  Description : Collects SWITCH / SWITCH_EXT beats into one CONF_W-bit
//                switch-memory word and emits a one-cycle done strobe with the
//                word, address and thread. Protocol violations (continuation
//                without a start, or a restart mid-word) pulse err_o.
//  Ports       : clk, rst         - clock, async active-high reset
//                sw_hit_i         - SWITCH beat addressed to this switch
//                ext_hit_i        - SWITCH_EXT beat addressed to this switch
//                payload_i        - 24-bit beat payload
//                addr_i/thread_i  - address and thread of a SWITCH beat
//                done_o           - word write strobe
//                err_o            - protocol violation pulse
//                data_o/waddr_o/thread_o - written word, held between writes
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_conf_assembler
  import branch_conf_pkg::*;
#(
  parameter int ADDR_W   = 1,
  parameter int THREAD_W = 3,
  parameter int CONF_W   = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sw_hit_i,
  input  logic                 ext_hit_i,
  input  logic [PAYLOAD_W-1:0] payload_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [THREAD_W-1:0]  thread_i,
  output logic                 done_o,
  output logic                 err_o,
  output logic [CONF_W-1:0]    data_o,
  output logic [ADDR_W-1:0]    waddr_o,
  output logic [THREAD_W-1:0]  thread_o
);

  localparam int         BEATS   = beats_for(CONF_W);
  localparam int         ASM_W   = BEATS * PAYLOAD_W;
  localparam logic [2:0] BEATS_C = 3'(BEATS);

  asm_state_e            state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [ASM_W-1:0]      asm_q, asm_d;
  logic [ADDR_W-1:0]     lat_addr_q, lat_addr_d;
  logic [THREAD_W-1:0]   lat_thread_q, lat_thread_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [CONF_W-1:0]     data_q, data_d;
  logic [ADDR_W-1:0]     waddr_q, waddr_d;
  logic [THREAD_W-1:0]   thread_q, thread_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      asm_q        <= '0;
      lat_addr_q   <= '0;
      lat_thread_q <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      data_q       <= '0;
      waddr_q      <= '0;
      thread_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      asm_q        <= asm_d;
      lat_addr_q   <= lat_addr_d;
      lat_thread_q <= lat_thread_d;
      done_q       <= done_d;
      err_q        <= err_d;
      data_q       <= data_d;
      waddr_q      <= waddr_d;
      thread_q     <= thread_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    asm_d        = asm_q;
    lat_addr_d   = lat_addr_q;
    lat_thread_d = lat_thread_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    data_d       = data_q;
    waddr_d      = waddr_q;
    thread_d     = thread_q;

    if (sw_hit_i) begin
      // A new start beat always wins; any partial word is abandoned.
      err_d                   = (state_q == ST_ASSEMBLE);
      asm_d                   = '0;
      asm_d[PAYLOAD_W-1:0]    = payload_i;
      lat_addr_d              = addr_i;
      lat_thread_d            = thread_i;
      if (BEATS == 1) begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        state_d = ST_ASSEMBLE;
        cnt_d   = 3'd1;
      end
    end else if (ext_hit_i) begin
      if (state_q == ST_ASSEMBLE) begin
        for (int b = 1; b < BEATS; b++) begin
          if (cnt_q == 3'(b)) begin
            asm_d[b*PAYLOAD_W +: PAYLOAD_W] = payload_i;
          end
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_d == BEATS_C) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end else begin
        err_d = 1'b1;
      end
    end

    // Bits of the final beat above CONF_W are dropped here.
    if (done_d) begin
      data_d   = asm_d[CONF_W-1:0];
      waddr_d  = lat_addr_d;
      thread_d = lat_thread_d;
    end
  end

  assign done_o   = done_q;
  assign err_o    = err_q;
  assign data_o   = data_q;
  assign waddr_o  = waddr_q;
  assign thread_o = thread_q;

endmodule

`default_nettype wire

// File: rtl/switch_conf_reader_branch_gen.sv
// ============================================================================
//  Module      : switch_conf_reader_branch_gen
//  Description : Configuration decoder for one branch-network switch. Snoops
//                the 64-bit configuration bus, registers the fields of words
//                addressed to SWITCH_NUMBER, drives the PC-max / PC-loop
//                registers and writes assembled switch-memory words.
//                Two-cycle latency from bus sample to output strobe.
//  Macro       : SWITCH_CONF_READER_BCAST_EN - when defined, switch number
//                16'hFFFF also addresses this switch.
//  Ports       : clk, rst              - clock, async active-high reset
//                conf_bus_in/conf_valid - configuration bus
//                pc_max/pc_max_we       - PC maximum and its write strobe
//                pc_loop/pc_loop_we     - PC loop value and its write strobe
//                thread_id              - thread of the last memory write
//                net_mem_we/_waddr/_data - switch-memory write port
//                conf_err               - protocol violation pulse
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module switch_conf_reader_branch_gen
  import branch_conf_pkg::*;
#(
  parameter logic [15:0] SWITCH_NUMBER = 16'd1,
  parameter int          PC_W          = 1,
  parameter int          THREAD_W      = 3,
  parameter int          ADDR_W        = 1,
  parameter int          CONF_W        = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [63:0]         conf_bus_in,
  input  logic                conf_valid,
  output logic [PC_W-1:0]     pc_max,
  output logic                pc_max_we,
  output logic [PC_W-1:0]     pc_loop,
  output logic                pc_loop_we,
  output logic [THREAD_W-1:0] thread_id,
  output logic                net_mem_we,
  output logic [ADDR_W-1:0]   net_mem_waddr,
  output logic [CONF_W-1:0]   net_mem_data,
  output logic                conf_err
);

  logic [NUM_W-1:0] w_num;
  logic             w_match;
  logic             w_unused_bus;

  assign w_num = conf_bus_in[NUM_LSB +: NUM_W];

`ifdef SWITCH_CONF_READER_BCAST_EN
  assign w_match = (w_num == SWITCH_NUMBER) || (w_num == BCAST_ID);
`else
  assign w_match = (w_num == SWITCH_NUMBER);
`endif

  // Depending on the parameters, some bus bits feed no field.
  assign w_unused_bus = ^conf_bus_in;

  // ---------------- Stage 1: field registration and hit decode -------------
  logic                 s1_hit_q;
  logic [TYPE_W-1:0]    s1_type_q;
  logic [THREAD_W-1:0]  s1_thread_q;
  logic [ADDR_W-1:0]    s1_addr_q;
  logic [PAYLOAD_W-1:0] s1_payload_q;
  logic [PC_W-1:0]      s1_pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_hit_q     <= 1'b0;
      s1_type_q    <= '0;
      s1_thread_q  <= '0;
      s1_addr_q    <= '0;
      s1_payload_q <= '0;
      s1_pc_q      <= '0;
    end else begin
      s1_hit_q <= conf_valid && w_match;
      if (conf_valid) begin
        s1_type_q    <= conf_bus_in[TYPE_LSB +: TYPE_W];
        s1_thread_q  <= conf_bus_in[THREAD_LSB +: THREAD_W];
        s1_addr_q    <= conf_bus_in[ADDR_LSB +: ADDR_W];
        s1_payload_q <= conf_bus_in[PAYLOAD_LSB +: PAYLOAD_W];
        s1_pc_q      <= conf_bus_in[PC_LSB +: PC_W];
      end
    end
  end

  // ---------------- Stage 2: PC registers ----------------------------------
  logic            w_pc_max_hit, w_pc_loop_hit, w_sw_hit, w_ext_hit;
  logic [PC_W-1:0] pc_max_q, pc_loop_q;
  logic            pc_max_we_q, pc_loop_we_q;

  assign w_pc_max_hit  = s1_hit_q && (s1_type_q == TYPE_SET_PC_MAX);
  assign w_pc_loop_hit = s1_hit_q && (s1_type_q == TYPE_SET_PC_LOOP);
  assign w_sw_hit      = s1_hit_q && (s1_type_q == TYPE_SWITCH);
  assign w_ext_hit     = s1_hit_q && (s1_type_q == TYPE_SWITCH_EXT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_max_q     <= '0;
      pc_loop_q    <= '0;
      pc_max_we_q  <= 1'b0;
      pc_loop_we_q <= 1'b0;
    end else begin
      pc_max_we_q  <= w_pc_max_hit;
      pc_loop_we_q <= w_pc_loop_hit;
      if (w_pc_max_hit) begin
        pc_max_q <= s1_pc_q;
      end
      if (w_pc_loop_hit) begin
        pc_loop_q <= s1_pc_q;
      end
    end
  end

  // ---------------- Stage 2: switch-word assembly --------------------------
  branch_conf_assembler #(
    .ADDR_W   (ADDR_W),
    .THREAD_W (THREAD_W),
    .CONF_W   (CONF_W)
  ) u_assembler (
    .clk       (clk),
    .rst       (rst),
    .sw_hit_i  (w_sw_hit),
    .ext_hit_i (w_ext_hit),
    .payload_i (s1_payload_q),
    .addr_i    (s1_addr_q),
    .thread_i  (s1_thread_q),
    .done_o    (net_mem_we),
    .err_o     (conf_err),
    .data_o    (net_mem_data),
    .waddr_o   (net_mem_waddr),
    .thread_o  (thread_id)
  );

  assign pc_max     = pc_max_q;
  assign pc_max_we  = pc_max_we_q;
  assign pc_loop    = pc_loop_q;
  assign pc_loop_we = pc_loop_we_q;

endmodule

`default_nettype wire

// File: doc/switch_conf_reader_branch_gen.md
# switch_conf_reader_branch_gen

Parametrised configuration decoder for one switch of the CGRA branch network. It snoops the 64-bit configuration bus and matches words addressed to its switch number or, optionally, to the broadcast number. It drives PC-max/PC-loop register writes and writes one switch-memory word per instruction address. Switch words wider than the 24-bit bus payload are assembled from several consecutive beats.

## Interface
- SWITCH_NUMBER, 1: 16-bit switch id this instance answers to.
- PC_W, 1: width of pc_max / pc_loop (1..32).
- THREAD_W, 3: width of thread_id (1..4).
- ADDR_W, 1: switch-memory address width (1..12).
- CONF_W, 24: switch-memory word width (1..96); BEATS = ceil(CONF_W/24), 1..4.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset: asynchronous and active-high; clears all state and outputs.
- conf_bus_in  in  64  configuration word.
- conf_valid  in  1  qualifies conf_bus_in; ignored when low.
- pc_max  out  PC_W  PC maximum value; pc_max_we  out  1  one-cycle write strobe.
- pc_loop  out  PC_W  PC loop value; pc_loop_we  out  1  one-cycle write strobe.
- thread_id  out  THREAD_W  thread of the current write.
- net_mem_we  out  1  one-cycle switch-memory write strobe.
- net_mem_waddr  out  ADDR_W  switch-memory address.
- net_mem_data  out  CONF_W  assembled switch word.
- conf_err  out  1  one-cycle pulse on a protocol violation.

## Operation
- Bus fields: [7:0] type, [23:8] switch number, [27:24] thread, [39:28] instruction address, [63:40] 24-bit payload, [63:32] PC value.
- Types: 11 SET_PC_MAX, 12 SET_PC_LOOP, 13 SWITCH (first beat), 14 SWITCH_EXT (continuation beat). Any other type is ignored without error.
- Stage 1: when conf_valid is high, register the fields and set hit to (number == SWITCH_NUMBER). When conf_valid is low, hit is 0.
- Stage 2 acts on a hit:
  - PC_MAX: pc_max <= PC[PC_W-1:0] and pc_max_we pulses. PC_LOOP behaves the same way with pc_loop and pc_loop_we.
  - SWITCH: latch addr[ADDR_W-1:0] and thread[THREAD_W-1:0]. Put the payload in bits [23:0] of the assembly register and clear the upper bits. If BEATS==1, write immediately. Otherwise enter ASSEMBLE with beat count 1.
  - SWITCH_EXT in ASSEMBLE: put the payload in bits [24k+23:24k], where k is the beat count, and truncate the final beat to CONF_W. Increment the count. When the count reaches BEATS, write and return to IDLE.
- FSM states are IDLE and ASSEMBLE. Only a hit with type 13 or 14 changes state.
- Boundary cases:
  - SWITCH_EXT in IDLE, or any SWITCH_EXT when BEATS==1: drop it and pulse conf_err.
  - SWITCH in ASSEMBLE: abandon the partial word, pulse conf_err and restart with the new beat.
  - PC_MAX or PC_LOOP in ASSEMBLE: apply it and stay in ASSEMBLE. Assembly is not aborted.
  - Non-hit or invalid cycles between beats are allowed; there is no timeout.
- A write sets net_mem_data to the assembled word and net_mem_waddr and thread_id to the latched values, and pulses net_mem_we.
- Strobes are never asserted together, because each stage-2 cycle handles one beat.

## Timing
- Latency is 2 cycles. A beat sampled at edge N produces its strobe and data visible after edge N+1.
- Multi-beat writes: net_mem_we follows 2 cycles after the final beat.
- All strobes deassert the cycle after they assert.
- Data outputs hold their value between writes.
- Back-to-back beats are accepted at 1 per cycle. No backpressure exists.
- Reset clears every output, the stage-1 registers, the assembly register and the beat count, and returns the FSM to IDLE. Reset asserted mid-assembly discards the partial word with no write and no conf_err.

## Configuration
- SWITCH_CONF_READER_BCAST_EN defined: switch number 16'hFFFF also produces a hit for every type, so one bus word configures all switches.
- Undefined: 16'hFFFF is treated as an ordinary number. It matches only if SWITCH_NUMBER equals it.

## Structure
- Shared package branch_conf_pkg holds:
  - type constants 11–14;
  - BCAST_ID = 16'hFFFF;
  - field offsets and widths, and PAYLOAD_W = 24;
  - the FSM state enum.
- Sub-module branch_conf_assembler holds the beat counter, the IDLE/ASSEMBLE FSM and the CONF_W assembly register. Its outputs are a done strobe and an error pulse.
- The top level does field registration, hit decode and the PC registers.

## Test plan
- PC_W=8 instance: type 11 with number 1 and PC 0x0000_00A5 -> pc_max=0xA5 and pc_max_we pulses for 1 cycle, 2 cycles after the beat. The same word with number 2 -> no strobe.
- CONF_W=60 (BEATS=3), ADDR_W=4: type 13 with addr 5, thread 2, payload 0x111111, then type 14 with payload 0x222222, then type 14 with payload 0xF33333 -> one net_mem_we. Result: waddr=5, thread_id=2, data=0x333_222222_111111.
- CONF_W=48: type 13, then type 13 again with payload 0xABCDEF, then type 14 with 0x000001 -> conf_err on the second beat. Result: a single write with data=0x000001_ABCDEF.
- SWITCH_EXT in IDLE -> conf_err pulses, no write, state stays IDLE.
- rst asserted between beat 1 and beat 2 of a 2-beat word -> all outputs 0. A following type 14 -> conf_err, no write.
- With SWITCH_CONF_READER_BCAST_EN, type 12 with number 0xFFFF -> pc_loop_we pulses. Without the macro -> no strobe.
